// File: rtl/uart_rx_core_if.sv
// Receive-side bundle for uart_rx_core: serial line in, recovered byte and status pulses out.
// master = the receiver, slave = the line driver / byte consumer.
interface uart_rx_core_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_intr;
  logic       frame_err;
  logic       parity_err;

  modport master (
    input  rx,
    output rx_data, rx_valid, rx_intr, frame_err, parity_err
  );

  modport slave (
    output rx,
    input  rx_data, rx_valid, rx_intr, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with internal baud timing and mid-bit sampling.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_rx_core #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_core_if.master  rxif
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TERM = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_TERM  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // Synchronizer plus a fill marker: an edge counts only once rxs carries the
  // real line level and that level has been seen high since reset.
  logic       rx_meta, rxs, rxs_d;
  logic [1:0] fill;
  logic       seen_hi;
  logic       fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
      fill    <= 2'b00;
      seen_hi <= 1'b0;
    end else begin
      rx_meta <= rxif.rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
      fill    <= {fill[0], 1'b1};
      if (fill[1] && rxs) seen_hi <= 1'b1;
    end
  end

  assign fall = seen_hi & rxs_d & ~rxs;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    data_q;
  logic          valid_q, intr_q, ferr_q;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, par_bad;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      intr_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      par_bad <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) begin
            state  <= START;
            intr_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_TERM) begin
            cnt <= '0;
            if (!rxs) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state  <= IDLE;
              intr_q <= 1'b0;
            end
          end
        end
        DATA: begin
          if (cnt == BIT_TERM) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_TERM) begin
            cnt     <= '0;
            par_bad <= rxs ^ (^shreg);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_TERM) begin
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            cnt    <= '0;
            state  <= IDLE;
            intr_q <= 1'b0;
            if (!rxs) begin
              ferr_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              perr_q <= 1'b1;
`endif
            end else begin
              data_q  <= shreg;
              valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          intr_q <= 1'b0;
        end
      endcase
    end
  end

  assign rxif.rx_data   = data_q;
  assign rxif.rx_valid  = valid_q;
  assign rxif.rx_intr   = intr_q;
  assign rxif.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rxif.parity_err = perr_q;
`else
  assign rxif.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed + randomized bench for uart_rx_core: frames are built bit by bit and the
// expected result of each frame comes from the line-level framing rules.
module tb_uart_rx_core;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int NOM_LAT = 2 + HALF + 9 * CPB;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   t_start = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx_core_if bus();

  uart_rx_core #(.CLK_FREQ(50_000_000), .BAUD(9600), .CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .rst  (rst),
    .rxif (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;      // 0 = valid, 1 = frame error, 2 = parity error
    logic [7:0] data;
    logic       intr_now;
    logic       intr_prev;
    int         at;
  } ev_t;

  ev_t got[$];
  ev_t expq[$];
  logic intr_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: logs every status pulse with the surrounding rx_intr levels.
  always @(negedge clk) begin : mon
    ev_t e;
    if (rst && (bus.rx_valid || bus.frame_err || bus.parity_err)) begin
      check("pulse_exclusive", $countones({bus.rx_valid, bus.frame_err, bus.parity_err}), 1);
      e.kind      = bus.rx_valid ? 0 : (bus.frame_err ? 1 : 2);
      e.data      = bus.rx_data;
      e.intr_now  = bus.rx_intr;
      e.intr_prev = intr_q;
      e.at        = cyc;
      got.push_back(e);
    end
    intr_q = bus.rx_intr;
  end

  function automatic ev_t model(input logic [7:0] d, input logic stop, input logic par);
    ev_t e;
    e.intr_now  = 1'b0;
    e.intr_prev = 1'b1;
    e.at        = 0;
    e.data      = d;
    if (!stop)                      e.kind = 1;
    else if (PAR_EN && (par != ^d)) e.kind = 2;
    else                            e.kind = 0;
    return e;
  endfunction

  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int nbits);
    bus.rx = 1'b1;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    logic par;
    ev_t  e;
    par = (^d) ^ par_flip;
    e = model(d, stop, par);
    if (e.kind == 0) last_good = d;
    else e.data = last_good;
    expq.push_back(e);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic compare_events(input string tag);
    ev_t g, x;
    check({tag, "_count"}, got.size(), expq.size());
    while (got.size() > 0 && expq.size() > 0) begin
      g = got.pop_front();
      x = expq.pop_front();
      check({tag, "_kind"},      g.kind,      x.kind);
      check({tag, "_data"},      g.data,      x.data);
      check({tag, "_intr_low"},  g.intr_now,  x.intr_now);
      check({tag, "_intr_fell"}, g.intr_prev, x.intr_prev);
    end
    got.delete();
    expq.delete();
  endtask

  initial begin
    logic [7:0] d96;
    int lat;
    bus.rx = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_data",    bus.rx_data,    8'h00);
    check("rst_rx_valid",   bus.rx_valid,   1'b0);
    check("rst_rx_intr",    bus.rx_intr,    1'b0);
    check("rst_frame_err",  bus.frame_err,  1'b0);
    check("rst_parity_err", bus.parity_err, 1'b0);
    rst = 1'b1;
    idle(2);

    // Two fixed bytes, latency of the first, then random bytes
    send_frame(8'h55, 1'b1, 1'b0);
    lat = (got.size() > 0) ? got[0].at - t_start : -1;
    check("latency_window", (lat >= NOM_LAT - 1 && lat <= NOM_LAT + 1), 1'b1);
    send_frame(8'hA3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      send_frame(8'($urandom), 1'b1, 1'b0);
    end
    idle(1);
    compare_events("t1");

    // Short low glitch: start is entered, then abandoned
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_intr_up", bus.rx_intr, 1'b1);
    repeat (14) @(negedge clk);
    check("glitch_intr_down", bus.rx_intr, 1'b0);
    idle(2);
    compare_events("t2");

    // Bad stop bit, then a held-low break line
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (30 * CPB) @(negedge clk);
    check("break_intr", bus.rx_intr, 1'b0);
    check("break_data_held", bus.rx_data, last_good);
    compare_events("t3");
    idle(2);
    send_frame(8'($urandom), 1'b1, 1'b0);
    idle(1);
    compare_events("t3_recover");

    // Back-to-back frames, no idle between stop and next start
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    send_frame(8'($urandom), 1'b1, 1'b0);
    send_frame(8'($urandom), 1'b1, 1'b0);
    idle(1);
    compare_events("t4");

    // Reset in the middle of data bit 4
    d96 = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d96[i]);
    bus.rx = d96[4];
    repeat (HALF) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rx_data",    bus.rx_data,    8'h00);
    check("midrst_rx_valid",   bus.rx_valid,   1'b0);
    check("midrst_rx_intr",    bus.rx_intr,    1'b0);
    check("midrst_frame_err",  bus.frame_err,  1'b0);
    check("midrst_parity_err", bus.parity_err, 1'b0);
    last_good = 8'h00;
    // Line low across reset release must not look like a start edge
    bus.rx = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    idle(12);
    check("lowrel_intr", bus.rx_intr, 1'b0);
    compare_events("t5_quiet");
    send_frame(8'h96, 1'b1, 1'b0);
    idle(1);
    compare_events("t5");
    check("t5_data", bus.rx_data, 8'h96);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(1);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(1);
    send_frame(8'($urandom), 1'b1, 1'b1);
    idle(1);
    send_frame(8'($urandom), 1'b0, 1'b1);
    idle(1);
    send_frame(8'($urandom), 1'b1, 1'b0);
    idle(1);
    compare_events("t6");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
